// File: rtl/fpu_alu_arbiter.sv
// fpu_alu_arbiter
//   Shares one external combinational float32 add/sub unit (fpu_alu) between
//   NUM_REQ requesters. A round-robin arbiter feeds a two-stage pipeline:
//   S1 holds the granted operands and drives the ALU directly, and S2 captures
//   the ALU result and presents it on a single valid/ready response channel
//   tagged with the requester index.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     per-requester handshake (req_ready is one-hot or zero)
//   req_op                  per-requester op, 0 = A+B, 1 = A-B
//   req_a, req_b            flattened operands, requester i at [32i+31:32i]
//   alu_operation/operA/B   to fpu_alu, straight from the S1 registers
//   alu_result              from fpu_alu (combinational)
//   resp_valid/resp_ready   response handshake
//   resp_id, resp_data      requester index and float32 result
//   busy                    either pipeline stage holds a valid entry
module fpu_alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_op,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic                  alu_operation,
  output logic [31:0]           alu_operA,
  output logic [31:0]           alu_operB,
  input  logic [31:0]           alu_result,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_data,
  output logic                  busy
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  logic            s1_valid;
  logic [ID_W-1:0] s1_id;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] cand;
  logic [ID_W-1:0] grant_idx;
  logic            grant_found;
  logic            s2_free;
  logic            s1_adv;
  logic            s1_free;
  logic            handshake;
  logic            sel_op;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;

  assign s2_free   = !resp_valid | resp_ready;
  assign s1_adv    = s1_valid & s2_free;
  assign s1_free   = !s1_valid | s1_adv;
  assign handshake = s1_free & grant_found;
  assign busy      = s1_valid | resp_valid;

  // Search starts one past the last granted index and wraps at NUM_REQ-1,
  // which is not necessarily a power of two.
  always_comb begin
    cand        = rr_ptr;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == LAST_ID) ? '0 : cand + 1'b1;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (handshake) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_op = 1'b0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_op = req_op[i];
        sel_a  = req_a[i*32 +: 32];
        sel_b  = req_b[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= LAST_ID;
    end else if (handshake) begin
      rr_ptr <= grant_idx;
    end
  end

  // Operand registers only change on a new grant so the ALU inputs stay
  // stable while S1 is stalled or empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s1_id         <= '0;
      alu_operation <= 1'b0;
      alu_operA     <= '0;
      alu_operB     <= '0;
    end else if (handshake) begin
      s1_valid      <= 1'b1;
      s1_id         <= grant_idx;
      alu_operation <= sel_op;
      alu_operA     <= sel_a;
      alu_operB     <= sel_b;
    end else if (s1_adv) begin
      s1_valid      <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else if (s1_adv) begin
      resp_valid <= 1'b1;
      resp_id    <= s1_id;
      resp_data  <= alu_result;
    end else if (resp_valid && resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fpu_alu_arbiter.sv
module tb_fpu_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        alu_operation;
  logic [31:0] alu_operA;
  logic [31:0] alu_operB;
  logic [31:0] alu_result;
  logic        resp_valid;
  logic        resp_ready;
  logic [0:0]  resp_id;
  logic [31:0] resp_data;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          exp_id[$];
  logic [31:0] exp_data[$];
  int          grant_log[$];
  int          grant_cyc[$];
  int          resp_cyc[$];

  logic        s_op[8];
  logic [31:0] s_a[8];
  logic [31:0] s_b[8];

  logic        stall_prev = 1'b0;
  logic [31:0] hold_data;
  logic [0:0]  hold_id;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpu_alu_arbiter #(.NUM_REQ(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_operation(alu_operation), .alu_operA(alu_operA), .alu_operB(alu_operB),
    .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .busy(busy)
  );

  // Stand-in for the external fpu_alu: exact float32 results for the operand
  // pairs the tests use; anything else maps to an opaque but deterministic word.
  function automatic logic [31:0] fadd_ref(input logic op, input logic [31:0] a,
                                           input logic [31:0] b);
    if (!op && a == 32'h40600000 && b == 32'h3FA00000) return 32'h40980000;
    if ( op && a == 32'h40600000 && b == 32'h3FA00000) return 32'h40100000;
    if (!op && a == 32'h40000000 && b == 32'h3F800000) return 32'h40400000;
    if ( op && a == 32'h40000000 && b == 32'h3F800000) return 32'h3F800000;
    if (!op && a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
    if (!op && a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
    if (!op && a == 32'h40800000 && b == 32'h40800000) return 32'h41000000;
    return a ^ {b[15:0], b[31:16]} ^ {31'd0, op};
  endfunction

  assign alu_result = fadd_ref(alu_operation, alu_operA, alu_operB);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: expected result pushed at each request handshake, popped and
  // compared at each response handshake; also watches stall stability.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_onehot", 32'($countones(req_ready) > 1), 32'd0);
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          grant_log.push_back(i);
          grant_cyc.push_back(cyc);
          exp_id.push_back(i);
          exp_data.push_back(fadd_ref(req_op[i], req_a[32*i +: 32], req_b[32*i +: 32]));
        end
      end
      if (stall_prev) begin
        chk("stall_valid", 32'(resp_valid), 32'd1);
        chk("stall_data", resp_data, hold_data);
        chk("stall_id", 32'(resp_id), 32'(hold_id));
      end
      if (resp_valid && resp_ready) begin
        resp_cyc.push_back(cyc);
        if (exp_id.size() == 0) begin
          chk("resp_unexpected", 32'd1, 32'd0);
        end else begin
          chk("resp_id", 32'(resp_id), 32'(exp_id.pop_front()));
          chk("resp_data", resp_data, exp_data.pop_front());
        end
      end
      stall_prev = resp_valid && !resp_ready;
      hold_data  = resp_data;
      hold_id    = resp_id;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic load(input int id, input logic op, input logic [31:0] a, input logic [31:0] b);
    req_op[id]        = op;
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
  endtask

  // Presents s_* entries 0..n-1 from one requester, one per accepted
  // handshake; leaves req_valid high if the budget runs out first.
  task automatic stream(input int id, input int n, input int budget, output int acc);
    int  idx = 0;
    logic hs;
    load(id, s_op[0], s_a[0], s_b[0]);
    req_valid[id] = 1'b1;
    for (int c = 0; c < budget && idx < n; c++) begin
      @(negedge clk);
      hs = req_ready[id];
      @(posedge clk); #1;
      if (hs) begin
        idx++;
        if (idx < n) load(id, s_op[idx], s_a[idx], s_b[idx]);
        else req_valid[id] = 1'b0;
      end
    end
    acc = idx;
  endtask

  task automatic wait_drain();
    logic done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (exp_id.size() == 0 && !busy && !resp_valid) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc, gs, rs;
    logic [31:0] d0;
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, gs, rs;
    logic [31:0] d0;
    rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_alu_op", 32'(alu_operation), 32'd0);
    chk("rst_alu_a", alu_operA, 32'd0);
    chk("rst_alu_b", alu_operB, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single op, add then sub, latency 2
    s_op[0] = 1'b0; s_a[0] = 32'h40600000; s_b[0] = 32'h3FA00000;
    stream(0, 1, 10, acc);
    chk("single_add_acc", 32'(acc), 32'd1);
    wait_drain();
    chk("single_add_lat", 32'(resp_cyc[$] - grant_cyc[$]), 32'd2);
    s_op[0] = 1'b1;
    stream(0, 1, 10, acc);
    wait_drain();
    chk("single_sub_lat", 32'(resp_cyc[$] - grant_cyc[$]), 32'd2);

    // back-to-back from requester 1
    s_op[0] = 0; s_a[0] = 32'h3F800000; s_b[0] = 32'h3F800000;
    s_op[1] = 0; s_a[1] = 32'h40000000; s_b[1] = 32'h40000000;
    s_op[2] = 0; s_a[2] = 32'h40800000; s_b[2] = 32'h40800000;
    s_op[3] = 0; s_a[3] = 32'h40600000; s_b[3] = 32'h3FA00000;
    gs = grant_log.size(); rs = resp_cyc.size();
    stream(1, 4, 10, acc);
    wait_drain();
    chk("tput_count", 32'(acc), 32'd4);
    chk("tput_resp_count", 32'(resp_cyc.size() - rs), 32'd4);
    if (grant_cyc.size() >= gs + 4 && resp_cyc.size() >= rs + 4)
      for (int k = 0; k < 4; k++) begin
        chk("tput_grant_cyc", 32'(grant_cyc[gs+k]), 32'(grant_cyc[gs] + k));
        chk("tput_resp_cyc", 32'(resp_cyc[rs+k]), 32'(grant_cyc[gs] + 2 + k));
      end

    // round robin: both valid for 6 cycles
    load(0, 1'b0, 32'h40000000, 32'h3F800000);
    load(1, 1'b1, 32'h40000000, 32'h3F800000);
    gs = grant_log.size();
    req_valid = 2'b11;
    repeat (6) @(posedge clk);
    #1 req_valid = 2'b00;
    wait_drain();
    chk("rr_count", 32'(grant_log.size() - gs), 32'd6);
    for (int k = 0; k < 6; k++)
      if (gs + k < grant_log.size()) chk("rr_order", 32'(grant_log[gs+k]), 32'(k % 2));

    // backpressure: three requests with resp_ready low
    resp_ready = 1'b0;
    s_op[0] = 0; s_a[0] = 32'h3F800000; s_b[0] = 32'h3F800000;
    s_op[1] = 0; s_a[1] = 32'h40000000; s_b[1] = 32'h40000000;
    s_op[2] = 0; s_a[2] = 32'h40800000; s_b[2] = 32'h40800000;
    rs = resp_cyc.size();
    stream(0, 3, 6, acc);
    chk("bp_accepted", 32'(acc), 32'd2);
    @(negedge clk);
    chk("bp_ready", 32'(req_ready), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    d0 = resp_data;
    chk("bp_data", d0, 32'h40000000);
    repeat (3) @(negedge clk);
    chk("bp_hold", resp_data, d0);
    @(posedge clk); #1 resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_drain();
    chk("bp_resp_count", 32'(resp_cyc.size() - rs), 32'd3);
    if (resp_cyc.size() >= rs + 3)
      for (int k = 1; k < 3; k++)
        chk("bp_no_gap", 32'(resp_cyc[rs+k]), 32'(resp_cyc[rs] + k));

    // idle for 10 cycles, then next grant follows last granted (0)
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_ready", 32'(req_ready), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end
    @(posedge clk); #1;
    load(0, 1'b0, 32'h40000000, 32'h3F800000);
    load(1, 1'b1, 32'h40000000, 32'h3F800000);
    req_valid = 2'b11;
    @(negedge clk);
    chk("idle_next_grant", 32'(req_ready), 32'd2);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_drain();

    // reset with both stages full, last grant to requester 0
    resp_ready = 1'b0;
    s_op[0] = 0; s_a[0] = 32'h3F800000; s_b[0] = 32'h3F800000;
    s_op[1] = 0; s_a[1] = 32'h40000000; s_b[1] = 32'h40000000;
    stream(0, 2, 6, acc);
    chk("prerst_acc", 32'(acc), 32'd2);
    chk("prerst_resp_valid", 32'(resp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_alu_a", alu_operA, 32'd0);
    chk("midrst_alu_b", alu_operB, 32'd0);
    chk("midrst_alu_op", 32'(alu_operation), 32'd0);
    exp_id.delete(); exp_data.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b1;
    load(0, 1'b0, 32'h40000000, 32'h3F800000);
    load(1, 1'b1, 32'h40000000, 32'h3F800000);
    rs = resp_cyc.size();
    req_valid = 2'b11;
    @(negedge clk);
    chk("postrst_first_grant", 32'(req_ready), 32'd1);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_drain();
    chk("postrst_resp_count", 32'(resp_cyc.size() - rs), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
